// File: rtl/act_unit_pipe.sv
// rtl/act_unit_pipe.sv - 3-stage streaming activation unit (SiLU, sigmoid, ReLU, bypass)
module act_unit_pipe #(
    parameter int DIM          = 4,
    parameter int WIDTH        = 16,
    parameter int FRAC         = 8,
    parameter int SEG_BITS     = 8,
    parameter int X_RANGE_LOG2 = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_mode,
    input  logic [DIM*WIDTH-1:0] in_vec,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DIM*WIDTH-1:0] out_vec,
    output logic [31:0]          beat_count
);
    localparam int STEP_BITS = X_RANGE_LOG2 - SEG_BITS;
    localparam int HALF_STEP = 2**(STEP_BITS-1);
    localparam int NLUT      = 2**SEG_BITS + 1;
    localparam int CTR       = 2**(SEG_BITS-1);
    localparam int X_MIN_Q   = -(2**(X_RANGE_LOG2-1));
    localparam int X_MAX_Q   = 2**(X_RANGE_LOG2-1);
    localparam int Q_BITS    = 40;
    localparam int PW        = 2*WIDTH + 1;
    localparam int HALF      = 2**(FRAC-1);
    localparam int SAT_MAX   = 2**(WIDTH-1) - 1;
    localparam int SAT_MIN   = -(2**(WIDTH-1));

    // Sigmoid ROM built from a fixed-point exp: t = e^(m*step) by repeated products of
    // a Taylor-series e^step, mirrored around the x=0 entry at index CTR.
    function automatic logic [NLUT*WIDTH-1:0] build_lut();
        logic [NLUT*WIDTH-1:0] tbl;
        logic [127:0] one, e_step, term, t, num, den, q;
        one    = 128'd1 << Q_BITS;
        e_step = '0;
        term   = one;
        for (int n = 1; n < 40; n++) begin
            e_step = e_step + term;
            term   = ((term << STEP_BITS) >> FRAC) / 128'(n);
        end
        tbl = '0;
        t   = one;
        for (int m = 0; m <= CTR; m++) begin
            den = one + t;
            q   = ((128'd1 << (FRAC + Q_BITS + 1)) + den) / (den << 1);
            tbl[(CTR - m)*WIDTH +: WIDTH] = WIDTH'(q);
            num = t << FRAC;
            q   = ((num << 1) + den) / (den << 1);
            tbl[(CTR + m)*WIDTH +: WIDTH] = WIDTH'(q);
            t   = (t * e_step) >> Q_BITS;
        end
        return tbl;
    endfunction

    localparam logic [NLUT*WIDTH-1:0] LUT = build_lut();

    function automatic logic signed [WIDTH-1:0] lut_at(input int i);
        return LUT[i*WIDTH +: WIDTH];
    endfunction

    logic                 r_s1_valid, r_s2_valid, r_out_valid;
    logic [1:0]           r_s1_mode, r_s2_mode;
    logic [DIM*WIDTH-1:0] r_s1_x, r_s2_x, r_s2_sig, r_out_vec;
    logic [31:0]          r_beat_count;
    logic                 w_adv;
    logic [DIM*WIDTH-1:0] w_sig_vec, w_res_vec;

    assign w_adv      = !r_out_valid || out_ready;
    assign in_ready   = w_adv;
    assign out_valid  = r_out_valid;
    assign out_vec    = r_out_vec;
    assign beat_count = r_beat_count;

    for (genvar j = 0; j < DIM; j++) begin : g_lane
        logic signed [WIDTH-1:0] w_x1, w_x2, w_s2, w_lo, w_hi;
        logic signed [31:0]      w_xc, w_interp;
        logic [X_RANGE_LOG2-1:0] w_off;
        logic [SEG_BITS-1:0]     w_idx;
        logic [STEP_BITS-1:0]    w_fr;
        logic signed [PW-1:0]    w_p, w_pr, w_res;

        assign w_x1     = r_s1_x[j*WIDTH +: WIDTH];
        assign w_xc     = (int'(w_x1) < X_MIN_Q)     ? X_MIN_Q :
                          (int'(w_x1) > X_MAX_Q - 1) ? X_MAX_Q - 1 : int'(w_x1);
        assign w_off    = X_RANGE_LOG2'(w_xc - X_MIN_Q);
        assign w_idx    = w_off[X_RANGE_LOG2-1:STEP_BITS];
        assign w_fr     = w_off[STEP_BITS-1:0];
        assign w_lo     = lut_at(int'(w_idx));
        assign w_hi     = lut_at(int'(w_idx) + 1);
        assign w_interp = int'(w_lo) +
                          (((int'(w_hi) - int'(w_lo)) * int'(w_fr) + HALF_STEP) >>> STEP_BITS);
        // Inputs at or beyond the top of the domain pin to the last table entry.
        assign w_sig_vec[j*WIDTH +: WIDTH] = (int'(w_x1) >= X_MAX_Q) ? lut_at(NLUT-1)
                                                                     : WIDTH'(w_interp);

        assign w_x2 = r_s2_x[j*WIDTH +: WIDTH];
        assign w_s2 = r_s2_sig[j*WIDTH +: WIDTH];
        assign w_p  = PW'(w_x2) * PW'(w_s2);
        assign w_pr = (w_p >= 0) ? (w_p + PW'(HALF)) >>> FRAC
                                 : (w_p + PW'(HALF - 1)) >>> FRAC;

        always_comb begin
            w_res = PW'(w_x2);
            case (r_s2_mode)
                2'b00:   w_res = w_pr;
                2'b01:   w_res = PW'(w_s2);
                2'b10:   w_res = w_x2[WIDTH-1] ? '0 : PW'(w_x2);
                default: w_res = PW'(w_x2);
            endcase
        end

        assign w_res_vec[j*WIDTH +: WIDTH] = (w_res > PW'(SAT_MAX)) ? WIDTH'(SAT_MAX) :
                                             (w_res < PW'(SAT_MIN)) ? WIDTH'(SAT_MIN) :
                                             w_res[WIDTH-1:0];
    end

    // All stages move together on w_adv so bubbles and stalls keep beats in order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_mode    <= '0;
            r_s1_x       <= '0;
            r_s2_valid   <= 1'b0;
            r_s2_mode    <= '0;
            r_s2_x       <= '0;
            r_s2_sig     <= '0;
            r_out_valid  <= 1'b0;
            r_out_vec    <= '0;
            r_beat_count <= '0;
        end else begin
            if (w_adv) begin
                r_s1_valid  <= in_valid;
                r_s1_mode   <= in_mode;
                r_s1_x      <= in_vec;
                r_s2_valid  <= r_s1_valid;
                r_s2_mode   <= r_s1_mode;
                r_s2_x      <= r_s1_x;
                r_s2_sig    <= w_sig_vec;
                r_out_valid <= r_s2_valid;
                r_out_vec   <= w_res_vec;
            end
            if (r_out_valid && out_ready) begin
                r_beat_count <= r_beat_count + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_act_unit_pipe.sv
// tb/tb_act_unit_pipe.sv - vector table plus scoreboard bench for act_unit_pipe
module tb_act_unit_pipe;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [1:0]  in_mode;
    logic [63:0] in_vec, out_vec;
    logic [31:0] beat_count;

    int          total = 0;
    int          bad = 0;
    logic [63:0] sb_q[$];
    int          lut_m[257];
    logic        stall_seen = 1'b0;
    logic [63:0] stall_vec = '0;

    typedef struct {
        logic [1:0]  mode;
        logic [63:0] vec;
        logic [63:0] exp;
    } vec_t;
    vec_t tbl[10];

    act_unit_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mode    (in_mode),
        .in_vec     (in_vec),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_vec    (out_vec),
        .beat_count (beat_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_lane(input logic [1:0] mode, input logic [15:0] xv);
        int x, xc, off, idx, fr, sig, p, r;
        x   = int'($signed(xv));
        xc  = (x < -2048) ? -2048 : ((x > 2047) ? 2047 : x);
        off = xc + 2048;
        idx = off / 16;
        fr  = off % 16;
        if (x >= 2048) sig = lut_m[256];
        else sig = lut_m[idx] + (((lut_m[idx+1] - lut_m[idx]) * fr + 8) >>> 4);
        case (mode)
            2'd0: begin
                p = x * sig;
                r = (p >= 0) ? (p + 128) / 256 : -((-p + 128) / 256);
            end
            2'd1:    r = sig;
            2'd2:    r = (x < 0) ? 0 : x;
            default: r = x;
        endcase
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r[15:0];
    endfunction

    function automatic logic [63:0] model_vec(input logic [1:0] mode, input logic [63:0] v);
        logic [63:0] o;
        for (int j = 0; j < 4; j++) o[j*16 +: 16] = model_lane(mode, v[j*16 +: 16]);
        return o;
    endfunction

    // Drives one beat and records its expected result once the handshake is seen.
    task automatic send(input logic [1:0] m, input logic [63:0] v, input logic [63:0] e);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_mode  = m;
        in_vec   = v;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
        end else begin
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_seen = 1'b0;
        end else begin
            if (stall_seen) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_vec", out_vec, stall_vec);
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_extra: got beat %h, required none", out_vec);
                end else begin
                    check("beat", out_vec, sb_q.pop_front());
                end
            end
            stall_seen = out_valid && !out_ready;
            stall_vec  = out_vec;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          r;
        logic [63:0] v;
        for (int i = 0; i < 257; i++) begin
            lut_m[i] = int'($floor(256.0 / (1.0 + $exp(-(real'(i*16 - 2048) / 256.0))) + 0.5));
        end
        rst_n = 1'b0; in_valid = 1'b0; in_mode = 2'd0; in_vec = '0; out_ready = 1'b1;

        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_vec", out_vec, 64'd0);
        check("rst_beat_count", 64'(beat_count), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        send(2'd0, 64'h0100_0100_0100_0100, 64'h00BB_00BB_00BB_00BB);
        @(posedge clk); #1;
        check("lat_2_cycles", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("lat_3_cycles", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        check("lat_beat_count", 64'(beat_count), 64'd1);

        tbl[0] = '{2'd0, 64'h0100_0100_0100_0100, 64'h00BB_00BB_00BB_00BB};
        tbl[1] = '{2'd1, 64'h8000_7FFF_0100_0000, 64'h0000_0100_00BB_0080};
        tbl[2] = '{2'd0, 64'h0000_FF00_8000_7FFF, 64'h0000_FFBB_0000_7FFF};
        tbl[3] = '{2'd1, 64'h0008_0008_0008_0008, model_vec(2'd1, 64'h0008_0008_0008_0008)};
        tbl[4] = '{2'd2, 64'h7FFF_8000_0280_FF00, 64'h7FFF_0000_0280_0000};
        tbl[5] = '{2'd3, 64'h7FFF_FFFF_1234_8000, 64'h7FFF_FFFF_1234_8000};
        for (int i = 6; i < 10; i++) begin
            v[15:0] = 16'($urandom_range(0, 65535));
            for (int j = 1; j < 4; j++) begin
                r = int'($urandom_range(0, 5000)) - 2500;
                v[j*16 +: 16] = r[15:0];
            end
            tbl[i] = '{2'(i % 4), v, model_vec(2'(i % 4), v)};
        end
        for (int i = 0; i < 10; i++) send(tbl[i].mode, tbl[i].vec, tbl[i].exp);
        repeat (8) @(posedge clk);
        #1;
        check("tbl_drain", 64'(sb_q.size()), 64'd0);
        check("tbl_beat_count", 64'(beat_count), 64'd11);

        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    for (int j = 0; j < 4; j++) v[j*16 +: 16] = 16'(k*4 + j + 16'h0040);
                    send(2'd3, v, v);
                end
            end
            begin
                for (int c = 0; c < 60; c++) begin
                    out_ready = (c % 3 == 0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        repeat (8) @(posedge clk);
        #1;
        check("bp_drain", 64'(sb_q.size()), 64'd0);
        check("bp_beat_count", 64'(beat_count), 64'd10);

        send(2'd0, 64'h0100_0100_0100_0100, 64'h00BB_00BB_00BB_00BB);
        send(2'd2, 64'h0280_FF00_0280_FF00, 64'h0280_0000_0280_0000);
        send(2'd1, 64'h0000_0000_0000_0000, 64'h0080_0080_0080_0080);
        send(2'd2, 64'hFF00_0280_FF00_0280, 64'h0000_0280_0000_0280);
        check("mix_busy", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_vec", out_vec, 64'd0);
        sb_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_idle", 64'(out_valid), 64'd0);
        check("post_rst_beat_count", 64'(beat_count), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/act_unit_pipe.md
Name: act_unit_pipe

Overview:
Streaming, pipelined multi-mode activation unit: the successor to the combinational SiLU LUT block. It processes DIM lanes of signed fixed-point data per beat. Modes are SiLU, sigmoid, ReLU and bypass. The sigmoid table is linearly interpolated, and the block sits between the matmul accumulator output and the next layer's input buffer behind valid/ready handshakes.

Parameters:
DIM, 4, number of parallel lanes per beat
WIDTH, 16, lane width in bits (signed two's complement)
FRAC, 8, fractional bits (Q(WIDTH-FRAC).FRAC)
SEG_BITS, 8, log2 of the number of LUT segments; the table holds 2^SEG_BITS+1 entries
X_RANGE_LOG2, 12, log2 of RANGE_Q; input domain is [-2^(X_RANGE_LOG2-1), +2^(X_RANGE_LOG2-1)] in Q units (default ±8.0)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_mode  in  2  00 SiLU, 01 sigmoid, 10 ReLU, 11 bypass; sampled with the beat
in_vec  in  DIM*WIDTH  lane j at [j*WIDTH +: WIDTH]
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_vec  out  DIM*WIDTH  results, same packing
beat_count  out  32  number of output beats transferred since reset; wraps

Behaviour:
- Reset (rst_n low, asynchronous): all stage valids clear, out_valid=0, out_vec=0, beat_count=0. in_ready=1 as soon as reset releases. Data in flight is discarded.
- Pipeline has 3 register stages. Global advance: adv = !out_valid || out_ready. in_ready = adv (combinational, no input-to-output path other than through adv). A beat is accepted when in_valid && in_ready.
- S1 stage: register x, mode, valid. Compute clamped xc = min(max(x, X_MIN_Q), X_MAX_Q - 1), then offset = xc - X_MIN_Q (unsigned, X_RANGE_LOG2 bits). idx = offset >> (X_RANGE_LOG2 - SEG_BITS); fr = the low (X_RANGE_LOG2 - SEG_BITS) bits. When x >= X_MAX_Q, force sig = lut[2^SEG_BITS] in S2 with no interpolation.
- S2 stage: sig = lut[idx] + ((lut[idx+1] - lut[idx]) * fr + 2^(STEP_BITS-1)) >>> STEP_BITS, where STEP_BITS = X_RANGE_LOG2 - SEG_BITS. Results are signed, WIDTH bits.
- LUT construction: lut[i] = round-half-away(sigmoid(x_i) * 2^FRAC), with x_i = (X_MIN_Q + i*2^STEP_BITS) / 2^FRAC. Built at elaboration; it is a constant ROM.
- S3 stage computes the output per mode:
  - SiLU: p = x * sig (2*WIDTH+1 bits), then round half away from zero and shift right by FRAC.
  - Sigmoid: sig.
  - ReLU: x<0 ? 0 : x.
  - Bypass: x.
- Final result saturates to [-2^(WIDTH-1), 2^(WIDTH-1)-1] before being registered.
- Latency is 3 cycles from acceptance to out_valid when out_ready is held high. Throughput is 1 beat per cycle.
- Backpressure: while out_valid && !out_ready, all stages hold, out_vec is stable, and in_ready=0. No bubbles are inserted and no beat is lost or duplicated.
- Bubbles propagate: a stage with valid=0 still advances on adv, so a later beat fills the gap.
- beat_count increments on out_valid && out_ready and wraps from 2^32-1 to 0.
- Mode travels with its beat. Mixed modes on consecutive beats are legal.
- Reset asserted mid-stream: outputs return to their reset values immediately, and in-flight beats are dropped.

Test Plan:
- Reset then SiLU, all lanes x=0x0100 (1.0), out_ready=1 -> out_valid exactly 3 cycles after acceptance, every lane 0x00BB (187); beat_count=1.
- Sigmoid mode, lanes {0x0000, 0x0100, 0x7FFF, 0x8000} -> {0x0080, 0x00BB, 0x0100, 0x0000}.
- SiLU with lanes {0x7FFF, 0x8000, 0xFF00 (-1.0), 0x0000} -> {0x7FFF, 0x0000, 0xFFBB (-69), 0x0000}. Checks sign, rounding and clamp.
- Interpolation: sigmoid at x=0x0008 (midway between grid points 0 and 16) -> (lut[128]+lut[129]+1)>>1 = 0x0080 + round((lut[129]-lut[128])/2); the bench compares against a golden model.
- Backpressure: stream 10 beats with incrementing x in bypass mode while toggling out_ready 1,0,0,1,... -> outputs in order, no loss or duplication, out_vec stable while stalled, beat_count=10.
- Mixed modes across consecutive beats with ReLU x=0xFF00 -> 0x0000 and x=0x0280 -> 0x0280. Then assert rst_n low mid-stream -> out_valid drops asynchronously, and beat_count=0 after release.
